// File: rtl/fetch_pkg.sv
// Shared definitions for the stage-1 fetch sequencer.
//   fetch_state_e : sequencer states (REQ, WAIT, HOLD, FAULT)
//   pc_sel_e      : next-PC source chosen by pc_next_mux
//   FETCH_ILEN    : default byte increment for sequential fetch
//   ALIGN_MASK    : low PC bits that must be zero for a legal fetch target
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ   = 2'd0,
        SEL_REDIR = 2'd1,
        SEL_TRAP  = 2'd2,
        SEL_HOLD  = 2'd3
    } pc_sel_e;

    localparam int         FETCH_ILEN = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select plus misalignment check (purely combinational).
// Priority: trap > redirect > sequential advance > hold current pc.
// Ports:
//   pc              : current program counter
//   advance         : a response is being accepted, step pc by ILEN
//   redirect_valid  : EX-stage branch/jump taken (already gated by caller)
//   redirect_target : redirect PC
//   trap_valid      : trap entry
//   trap_vector     : trap handler PC
//   sel             : chosen source (pc_sel_e encoding)
//   next_pc         : selected next PC
//   misaligned      : a redirect/trap target has non-zero low bits
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter int N    = 32,
    parameter int ILEN = FETCH_ILEN
) (
    input  logic [N-1:0] pc,
    input  logic         advance,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    input  logic         trap_valid,
    input  logic [N-1:0] trap_vector,
    output logic [1:0]   sel,
    output logic [N-1:0] next_pc,
    output logic         misaligned
);

    pc_sel_e sel_e;

    always_comb begin
        sel_e   = SEL_HOLD;
        next_pc = pc;
        if (trap_valid) begin
            sel_e   = SEL_TRAP;
            next_pc = trap_vector;
        end else if (redirect_valid) begin
            sel_e   = SEL_REDIR;
            next_pc = redirect_target;
        end else if (advance) begin
            sel_e   = SEL_SEQ;
            next_pc = pc + N'(ILEN);   // wraps modulo 2^N by width
        end
    end

    assign sel        = sel_e;
    assign misaligned = ((sel_e == SEL_TRAP) || (sel_e == SEL_REDIR)) &&
                        ((next_pc[1:0] & ALIGN_MASK) != 2'b00);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Stage-1 fetch sequencer: owns the PC, runs a single-outstanding
// request/grant/response handshake to instruction memory and presents
// fetched instructions to decode with valid/stall flow control.
// Ports:
//   clk, rst                        : clock, async active-high reset
//   stall_i                         : decode cannot accept this cycle
//   redirect_valid/redirect_target  : EX branch/jump redirect
//   trap_valid/trap_vector          : trap entry (beats redirect)
//   imem_req/imem_addr              : request out, address = pc
//   imem_gnt                        : request accepted this cycle
//   imem_rvalid/imem_rdata          : response
//   if_valid/if_pc/if_instr         : instruction presented to decode
//   fetch_fault                     : one-cycle pulse on misaligned target
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int           N         = 32,
    parameter logic [N-1:0] BOOT_ADDR = '0,
    parameter int           ILEN      = FETCH_ILEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    input  logic         trap_valid,
    input  logic [N-1:0] trap_vector,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic         if_valid,
    output logic [N-1:0] if_pc,
    output logic [31:0]  if_instr,
    output logic         fetch_fault
);

    fetch_state_e state, state_n;
    logic [N-1:0] pc, pc_n, if_pc_n, next_pc;
    logic [31:0]  instr_n;
    logic         kill, kill_n, req_n, vld_n, fault_n;
    logic [1:0]   sel;
    logic         misaligned, take, gnt_ok, held, advance, redir_ok;

    assign gnt_ok   = imem_req & imem_gnt;
    // decode still owns the current if_* contents after this cycle
    assign held     = if_valid & stall_i;
    // in FAULT only a trap may restart fetch, so redirects are ignored there
    assign redir_ok = redirect_valid & (state != FAULT);
    assign advance  = (state == WAIT) & imem_rvalid & ~kill & ~held;
    assign take     = (sel == SEL_REDIR) | (sel == SEL_TRAP);
    assign imem_addr = pc;

    pc_next_mux #(.N(N), .ILEN(ILEN)) u_mux (
        .pc              (pc),
        .advance         (advance),
        .redirect_valid  (redir_ok),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .sel             (sel),
        .next_pc         (next_pc),
        .misaligned      (misaligned)
    );

    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill;
        req_n   = 1'b0;
        vld_n   = held;          // accepted instructions drop out by default
        if_pc_n = if_pc;
        instr_n = if_instr;
        fault_n = 1'b0;
        if (take && misaligned) begin
            state_n = FAULT;
            kill_n  = 1'b0;
            vld_n   = 1'b0;
            fault_n = 1'b1;
        end else if (take) begin
            pc_n    = next_pc;
            vld_n   = 1'b0;
            state_n = REQ;
            req_n   = 1'b1;
            kill_n  = 1'b0;
            // a request already accepted by memory still owes a response:
            // wait for it and throw it away
            if ((state == REQ && gnt_ok) || (state == WAIT && !imem_rvalid)) begin
                state_n = WAIT;
                req_n   = 1'b0;
                kill_n  = 1'b1;
            end
        end else begin
            case (state)
                REQ: begin
                    if (gnt_ok) state_n = WAIT;
                    else        req_n   = 1'b1;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            kill_n  = 1'b0;
                            state_n = REQ;
                            req_n   = 1'b1;
                        end else if (held) begin
                            // previous instruction still stalled in decode:
                            // drop this response, pc unchanged, re-fetch later
                            state_n = HOLD;
                        end else begin
                            instr_n = imem_rdata;
                            if_pc_n = pc;
                            vld_n   = 1'b1;
                            pc_n    = next_pc;
                            if (stall_i) begin
                                state_n = HOLD;
                            end else begin
                                state_n = REQ;
                                req_n   = 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        state_n = REQ;
                        req_n   = 1'b1;
                    end
                end
                FAULT: begin
                    state_n = FAULT;
                end
                default: state_n = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= REQ;
            pc          <= BOOT_ADDR;
            kill        <= 1'b0;
            imem_req    <= 1'b0;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_instr    <= '0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            kill        <= kill_n;
            imem_req    <= req_n;
            if_valid    <= vld_n;
            if_pc       <= if_pc_n;
            if_instr    <= instr_n;
            fetch_fault <= fault_n;
        end
    end

endmodule
